// File: rtl/ofs_fim_pcie_ss_rx_hdr_extract_if.sv
// ---------------------------------------------------------------------------
// ofs_fim_pcie_ss_rx_hdr_extract_if
//
// Purpose : AXI-Stream style beat bus used on both sides of the RX header
//           extractor (aligned in-band stream in, side-band header stream out).
//
// Signals :
//   tvalid  beat valid (driven by master)
//   tready  beat accepted when tvalid && tready (driven by slave)
//   tdata   TDATA_WIDTH data bits
//   tkeep   TDATA_WIDTH/8 byte enables, contiguous from bit 0
//   tlast   end of packet
//   tuser   packed ofs_fim_pcie_ss_shims_pkg::t_tuser_seg
//
// Modports: master (drives the beat), slave (consumes the beat).
// ---------------------------------------------------------------------------
interface ofs_fim_pcie_ss_rx_hdr_extract_if #(
  parameter int TDATA_WIDTH = 512,
  // Default matches $bits(ofs_fim_pcie_ss_shims_pkg::t_tuser_seg); instantiators
  // should pass that expression explicitly.
  parameter int TUSER_WIDTH = 259
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/ofs_fim_pcie_ss_rx_hdr_extract.sv
// ---------------------------------------------------------------------------
// ofs_fim_pcie_ss_shims_pkg
//
// Per-packet tuser layout shared by the PCIe SS shims. hdr holds the PCIe SS
// header when hvalid is set; last_segment mirrors tlast on non-header beats.
// ---------------------------------------------------------------------------
package ofs_fim_pcie_ss_shims_pkg;
  localparam int SS_HDR_WIDTH = 256;

  typedef struct packed {
    logic                    dm_mode;
    logic                    last_segment;
    logic                    hvalid;
    logic [SS_HDR_WIDTH-1:0] hdr;
  } t_tuser_seg;
endpackage

// ---------------------------------------------------------------------------
// ofs_fim_pcie_ss_rx_hdr_extract
//
// Purpose : Consumes the aligned RX stream (at most one SOP per beat, always in
//           slot 0) whose SOP beat carries an in-band HDR_WIDTH-bit header in
//           the low bytes. The header moves to out tuser.hdr and the payload is
//           shifted down so payload byte 0 sits at tdata bit 0.
//
// Ports   :
//   clk     clock
//   rst_n   synchronous active-low reset
//   i_in    slave  side: aligned stream with in-band header
//   o_out   master side: byte-0 aligned payload, header in tuser
//
// Datapath: every output beat is {low H bytes of the current input beat,
//           upper B-H bytes of the previous input beat}. The upper part of
//           each accepted beat is kept in r_carry_*. When the last input beat
//           still has bytes above H, one extra TAIL beat flushes the carry.
// ---------------------------------------------------------------------------
module ofs_fim_pcie_ss_rx_hdr_extract
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int HDR_WIDTH   = 256,
  parameter int TUSER_WIDTH = $bits(t_tuser_seg)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  ofs_fim_pcie_ss_rx_hdr_extract_if.slave        i_in,
  ofs_fim_pcie_ss_rx_hdr_extract_if.master       o_out
);

  localparam int B     = TDATA_WIDTH / 8;          // bytes per beat
  localparam int H     = HDR_WIDTH / 8;            // header bytes
  localparam int CW    = TDATA_WIDTH - HDR_WIDTH;  // carried data bits
  localparam int CKW   = B - H;                    // carried keep bits
  localparam int SEG_W = $bits(t_tuser_seg);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } t_state;

  // ---------------------------------------------------------------- state
  t_state                 r_state;
  logic [CW-1:0]          r_carry_data;
  logic [CKW-1:0]         r_carry_keep;
  logic                   r_hdr_pend;
  t_tuser_seg             r_hdr_tuser;

  // Registered output stage
  logic                   r_out_tvalid;
  logic [TDATA_WIDTH-1:0] r_out_tdata;
  logic [B-1:0]           r_out_tkeep;
  logic                   r_out_tlast;
  t_tuser_seg             r_out_tuser;

  // ---------------------------------------------------------------- wires
  logic                   w_advance;
  logic                   w_in_fire;
  logic                   w_sop;
  logic                   w_upper_keep_nz;
  logic                   w_body_last;
  t_tuser_seg             w_in_tuser;
  t_tuser_seg             w_sop_tuser;
  logic [HDR_WIDTH-1:0]   w_in_lo_data;
  logic [CW-1:0]          w_in_hi_data;
  logic [H-1:0]           w_in_lo_keep;
  logic [CKW-1:0]         w_in_hi_keep;

  // Non-header beats carry only the last_segment marker.
  function automatic t_tuser_seg f_cont_tuser(input logic last);
    t_tuser_seg t;
    t              = '0;
    t.last_segment = last;
    return t;
  endfunction

  // The output register may load whenever it is empty or being drained.
  assign w_advance   = !r_out_tvalid || o_out.tready;
  // TAIL owns the output slot for one beat, so no input is taken then.
  assign i_in.tready = w_advance && (r_state != ST_TAIL);
  assign w_in_fire   = i_in.tvalid && i_in.tready;

  assign w_in_tuser      = SEG_W'(i_in.tuser);
  assign w_sop           = w_in_tuser.hvalid;
  assign w_in_lo_data    = i_in.tdata[HDR_WIDTH-1:0];
  assign w_in_hi_data    = i_in.tdata[TDATA_WIDTH-1:HDR_WIDTH];
  assign w_in_lo_keep    = i_in.tkeep[H-1:0];
  assign w_in_hi_keep    = i_in.tkeep[B-1:H];
  assign w_upper_keep_nz = |w_in_hi_keep;
  // A last beat with bytes above H spills into a TAIL beat, so the merged
  // beat only closes the packet when the upper half is empty.
  assign w_body_last     = i_in.tlast && !w_upper_keep_nz;

  // Captured tuser with the header moved into the side-band field.
  always_comb begin
    w_sop_tuser        = w_in_tuser;
    w_sop_tuser.hdr    = w_in_lo_data;
    w_sop_tuser.hvalid = 1'b1;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_out_tvalid <= 1'b0;
      r_hdr_pend   <= 1'b0;
      r_carry_keep <= '0;
    end else if (w_advance) begin
      // Output slot is free this cycle; it stays empty unless a beat lands.
      r_out_tvalid <= 1'b0;

      unique case (r_state)
        ST_IDLE, ST_BODY: begin
          if (w_in_fire) begin
            if (w_sop) begin
              // New packet. An SOP seen in BODY abandons the open packet:
              // its carry is overwritten here and never emitted.
              r_hdr_tuser  <= w_sop_tuser;
              r_carry_data <= w_in_hi_data;
              r_carry_keep <= w_in_hi_keep;
              if (i_in.tlast) begin
                r_out_tvalid <= 1'b1;
                r_out_tdata  <= {{HDR_WIDTH{1'b0}}, w_in_hi_data};
                r_out_tkeep  <= {{H{1'b0}}, w_in_hi_keep};
                r_out_tlast  <= 1'b1;
                r_out_tuser  <= w_sop_tuser;
                r_hdr_pend   <= 1'b0;
                r_state      <= ST_IDLE;
              end else begin
                // Header is held until the first merged beat can go out.
                r_hdr_pend   <= 1'b1;
                r_state      <= ST_BODY;
              end
            end else if (r_state == ST_BODY) begin
              r_carry_data <= w_in_hi_data;
              r_carry_keep <= w_in_hi_keep;
              r_out_tvalid <= 1'b1;
              r_out_tdata  <= {w_in_lo_data, r_carry_data};
              r_out_tkeep  <= {w_in_lo_keep, r_carry_keep};
              r_out_tlast  <= w_body_last;
              r_out_tuser  <= r_hdr_pend ? r_hdr_tuser : f_cont_tuser(w_body_last);
              r_hdr_pend   <= 1'b0;
              if (!i_in.tlast) begin
                r_state <= ST_BODY;
              end else if (w_upper_keep_nz) begin
                r_state <= ST_TAIL;
              end else begin
                r_state <= ST_IDLE;
              end
            end
            // Non-SOP beat in IDLE: dropped without touching any state.
          end
        end

        ST_TAIL: begin
          r_out_tvalid <= 1'b1;
          r_out_tdata  <= {{HDR_WIDTH{1'b0}}, r_carry_data};
          r_out_tkeep  <= {{H{1'b0}}, r_carry_keep};
          r_out_tlast  <= 1'b1;
          r_out_tuser  <= f_cont_tuser(1'b1);
          r_state      <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign o_out.tvalid = r_out_tvalid;
  assign o_out.tdata  = r_out_tdata;
  assign o_out.tkeep  = r_out_tkeep;
  assign o_out.tlast  = r_out_tlast;
  assign o_out.tuser  = TUSER_WIDTH'(r_out_tuser);

  // ---------------------------------------------------------------- checks
  // Upstream contract: packets start with an SOP beat, and no SOP arrives
  // while a packet is open.
  a_sop_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (w_in_fire && (r_state == ST_IDLE)) |-> w_sop);

  a_no_sop_in_body: assert property (@(posedge clk) disable iff (!rst_n)
    (w_in_fire && (r_state == ST_BODY)) |-> !w_sop);

  // Byte enables are a contiguous run starting at bit 0.
  a_keep_contig: assert property (@(posedge clk) disable iff (!rst_n)
    i_in.tvalid |-> ((i_in.tkeep & (i_in.tkeep + B'(1))) == '0));

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_hdr_extract.sv
module tb_ofs_fim_pcie_ss_rx_hdr_extract;
  import ofs_fim_pcie_ss_shims_pkg::*;

  localparam int TW = 512;
  localparam int HW = 256;
  localparam int B  = TW / 8;
  localparam int H  = HW / 8;
  localparam int UW = $bits(t_tuser_seg);

  logic clk;
  logic rst_n;

  ofs_fim_pcie_ss_rx_hdr_extract_if #(.TDATA_WIDTH(TW), .TUSER_WIDTH(UW)) in_if ();
  ofs_fim_pcie_ss_rx_hdr_extract_if #(.TDATA_WIDTH(TW), .TUSER_WIDTH(UW)) out_if ();

  ofs_fim_pcie_ss_rx_hdr_extract #(
    .TDATA_WIDTH(TW),
    .HDR_WIDTH  (HW),
    .TUSER_WIDTH(UW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .i_in (in_if),
    .o_out(out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] data;
    logic [B-1:0]  keep;
    logic          last;
    logic [UW-1:0] user;
    bit            emits;  // accepting this beat must load an output beat
    bit            tail;   // accepting this beat must be followed by a bubble
  } beat_t;

  beat_t in_q[$];
  beat_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int pkt_id = 0;
  int vld_pct = 100;
  int rdy_pct = 100;
  int hold_rdy0 = 0;

  bit            chk_lat = 0;
  bit            chk_tail = 0;
  bit            held_valid = 0;
  logic [TW-1:0] held_data;
  logic [B-1:0]  held_keep;
  logic          held_last;
  logic [UW-1:0] held_user;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] rand_vec();
    logic [TW-1:0] v;
    for (int w = 0; w < TW / 32; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [TW-1:0] keep_mask(input logic [B-1:0] k);
    logic [TW-1:0] m;
    for (int i = 0; i < B; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Reference model: a packet is a flat byte string (header then payload).
  // Output is the payload cut into B-byte beats (one empty beat if no payload),
  // first beat tagged with the header.
  task automatic send_pkt(input int plen);
    byte unsigned  pb[$];
    int            tot, nb, onb, idx;
    t_tuser_seg    su, eu, cu;
    logic [TW-1:0] tmp;
    beat_t         bt;
    tot = H + plen;
    nb  = (tot + B - 1) / B;
    onb = (plen == 0) ? 1 : (plen + B - 1) / B;
    for (int i = 0; i < tot; i++) pb.push_back(8'($urandom));
    tmp = rand_vec();
    su = '0;
    su.hdr          = tmp[HW-1:0];
    su.dm_mode      = 1'($urandom);
    su.last_segment = 1'($urandom);
    su.hvalid       = 1'b1;
    eu = su;
    for (int k = 0; k < H; k++) eu.hdr[8*k +: 8] = pb[k];
    for (int b = 0; b < nb; b++) begin
      bt.data = rand_vec();
      bt.keep = '0;
      for (int k = 0; k < B; k++) begin
        idx = b * B + k;
        if (idx < tot) begin
          bt.data[8*k +: 8] = pb[idx];
          bt.keep[k] = 1'b1;
        end
      end
      bt.last = (b == nb - 1);
      if (b == 0) begin
        bt.user = su;
      end else begin
        tmp = rand_vec();
        cu = t_tuser_seg'(tmp[UW-1:0]);
        cu.hvalid = 1'b0;
        bt.user = cu;
      end
      bt.emits = (b != 0) || (nb == 1);
      bt.tail  = (b == nb - 1) && (nb > 1) && (onb == nb);
      in_q.push_back(bt);
    end
    for (int o = 0; o < onb; o++) begin
      bt.data = '0;
      bt.keep = '0;
      for (int k = 0; k < B; k++) begin
        idx = o * B + k;
        if (idx < plen) begin
          bt.data[8*k +: 8] = pb[H + idx];
          bt.keep[k] = 1'b1;
        end
      end
      bt.last = (o == onb - 1);
      if (o == 0) begin
        bt.user = eu;
      end else begin
        cu = '0;
        cu.last_segment = bt.last;
        bt.user = cu;
      end
      bt.emits = 1'b0;
      bt.tail  = 1'b0;
      exp_q.push_back(bt);
    end
    $display("pkt %0d: payload %0d bytes, %0d in beats, %0d out beats", pkt_id, plen, nb, onb);
    pkt_id++;
  endtask

  task automatic cycle();
    beat_t e;
    bit    fire;
    @(negedge clk);
    if (in_q.size() != 0 && ($urandom_range(99) < vld_pct)) begin
      in_if.tvalid = 1'b1;
      in_if.tdata  = in_q[0].data;
      in_if.tkeep  = in_q[0].keep;
      in_if.tlast  = in_q[0].last;
      in_if.tuser  = in_q[0].user;
    end else begin
      in_if.tvalid = 1'b0;
    end
    if (hold_rdy0 > 0) begin
      out_if.tready = 1'b0;
      hold_rdy0--;
    end else begin
      out_if.tready = ($urandom_range(99) < rdy_pct);
    end
    #1;
    if (chk_lat) chk("latency_out_valid", 512'(out_if.tvalid), 512'(1));
    if (chk_tail) chk("tail_bubble_in_tready", 512'(in_if.tready), 512'(0));
    if (held_valid) begin
      chk("hold_tvalid", 512'(out_if.tvalid), 512'(1));
      chk("hold_tdata", out_if.tdata, held_data);
      chk("hold_tkeep", 512'(out_if.tkeep), 512'(held_keep));
      chk("hold_tlast", 512'(out_if.tlast), 512'(held_last));
      chk("hold_tuser", 512'(out_if.tuser), 512'(held_user));
    end
    if (out_if.tvalid && !out_if.tready) chk("bp_in_tready", 512'(in_if.tready), 512'(0));
    if (out_if.tvalid && out_if.tready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 512'(out_if.tvalid), 512'(0));
      end else begin
        e = exp_q.pop_front();
        chk("tkeep", 512'(out_if.tkeep), 512'(e.keep));
        chk("tdata", out_if.tdata & keep_mask(e.keep), e.data);
        chk("tlast", 512'(out_if.tlast), 512'(e.last));
        chk("tuser", 512'(out_if.tuser), 512'(e.user));
      end
    end
    held_valid = out_if.tvalid && !out_if.tready;
    held_data  = out_if.tdata;
    held_keep  = out_if.tkeep;
    held_last  = out_if.tlast;
    held_user  = out_if.tuser;
    fire     = in_if.tvalid && in_if.tready;
    chk_lat  = fire && in_q[0].emits;
    chk_tail = fire && in_q[0].tail;
    if (fire) void'(in_q.pop_front());
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_left", 512'(in_q.size() + exp_q.size()), 512'(0));
    repeat (3) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tkeep   = '0;
    in_if.tlast   = 1'b0;
    in_if.tuser   = '0;
    out_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_tvalid", 512'(out_if.tvalid), 512'(0));
    chk("rst_in_tready", 512'(in_if.tready), 512'(1));
    rst_n = 1'b1;

    // Header-only, 16 B payload, 2-in/1-out, 2-in/2-out (tail bubble)
    vld_pct = 100;
    rdy_pct = 100;
    send_pkt(0);   drain(50);
    send_pkt(16);  drain(50);
    send_pkt(64);  drain(50);
    send_pkt(96);  drain(50);

    // Backpressure for 5 cycles mid-packet
    send_pkt(200);
    cycle();
    cycle();
    hold_rdy0 = 5;
    drain(100);

    // Reset while the packet is open (first beat accepted, state BODY)
    send_pkt(150);
    cycle();
    chk("rst_setup_first_beat_taken", 512'(in_q.size()), 512'(2));
    @(negedge clk);
    rst_n = 1'b0;
    in_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midpkt_rst_out_tvalid", 512'(out_if.tvalid), 512'(0));
    chk("midpkt_rst_in_tready", 512'(in_if.tready), 512'(1));
    in_q.delete();
    exp_q.delete();
    chk_lat    = 0;
    chk_tail   = 0;
    held_valid = 0;
    send_pkt(100);
    drain(50);

    // Randomized traffic with valid gaps and random backpressure
    vld_pct = $urandom_range(50, 100);
    rdy_pct = $urandom_range(40, 100);
    for (int p = 0; p < 40; p++) send_pkt($urandom_range(0, 300));
    drain(20000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ofs_fim_pcie_ss_rx_hdr_extract.md
Name: ofs_fim_pcie_ss_rx_hdr_extract

Overview:
Downstream consumer of the RX segment aligner. It takes the aligned stream (at most one SOP per beat, always in slot 0, nothing valid after EOP) carrying in-band PCIe SS headers. It strips the header into a side-band field and shifts the payload down so payload byte 0 lands at tdata bit 0. Output feeds AFU-facing RX logic, which expects side-band headers with byte-0-aligned data.

Parameters:
TDATA_WIDTH, 512, data bus width in bits; must be a multiple of HDR_WIDTH and > HDR_WIDTH.
HDR_WIDTH, 256, in-band header width in bits (32 bytes).
TUSER_WIDTH, $bits(ofs_fim_pcie_ss_shims_pkg::t_tuser_seg), per-packet tuser width.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
in_tvalid  input  1  input beat valid
in_tready  output  1  input beat accepted when in_tvalid && in_tready
in_tdata  input  TDATA_WIDTH  input data; header in [HDR_WIDTH-1:0] on SOP beat
in_tkeep  input  TDATA_WIDTH/8  byte enables, contiguous from bit 0
in_tlast  input  1  end of packet
in_tuser  input  TUSER_WIDTH  t_tuser_seg; hvalid=1 marks SOP beat
out_tvalid  output  1  output beat valid
out_tready  input  1  downstream ready
out_tdata  output  TDATA_WIDTH  payload, byte-0 aligned
out_tkeep  output  TDATA_WIDTH/8  payload byte enables, contiguous from bit 0; may be 0
out_tlast  output  1  end of packet
out_tuser  output  TUSER_WIDTH  SOP beat: captured in_tuser with hdr field = header, hvalid=1; other beats: hvalid=0, last_segment=out_tlast

Behaviour:
- Notation: H = HDR_WIDTH/8 bytes, B = TDATA_WIDTH/8 bytes.
- Single registered output stage. advance = !out_tvalid || out_tready.
- in_tready = advance && state != TAIL. Output regs hold stable while out_tvalid && !out_tready.
- State registers:
  - state: IDLE / BODY / TAIL.
  - carry_data[TDATA_WIDTH-HDR_WIDTH-1:0] and carry_keep[B-H-1:0]: upper part of the previous input beat.
  - hdr_pend: header/tuser captured but not yet emitted.
- IDLE, beat accepted with hvalid=1:
  - Capture header = in_tdata[HDR_WIDTH-1:0] and in_tuser.
  - carry <= in_tdata/in_tkeep upper B-H bytes.
  - If in_tlast: emit one beat: data = {0, upper bytes}, keep = {0, in_tkeep[B-1:H]}, tlast=1, tuser hvalid=1; stay IDLE.
  - Else: no output this cycle; go BODY with hdr_pend=1.
- IDLE, beat with hvalid=0 (protocol violation): dropped, no output. Simulation-only assertion fires.
- BODY, beat accepted:
  - Emit data = {in_tdata[HDR_WIDTH-1:0], carry_data}, keep = {in_tkeep[H-1:0], carry_keep}.
  - tuser carries the header if hdr_pend; clear hdr_pend.
  - carry <= in upper bytes.
  - If !in_tlast: stay BODY, out_tlast=0.
  - If in_tlast && in_tkeep[B-1:H]==0: out_tlast=1, go IDLE.
  - If in_tlast && upper keep nonzero: out_tlast=0, go TAIL.
- TAIL, when advance: emit {0, carry_data}, keep {0, carry_keep}, tlast=1, hvalid=0; go IDLE. No input accepted this cycle.
- Header-only packet yields exactly one beat with out_tkeep=0, out_tlast=1, hvalid=1. Every packet yields >=1 output beat; the first carries hvalid=1.
- Latency:
  - Single-beat packet: output valid the cycle after acceptance.
  - Multi-beat packet: first output appears the cycle after the second input beat is accepted.
- Throughput: 1 beat/cycle, except one bubble per packet when TAIL is entered.
- hvalid=1 in BODY (SOP before EOP): assertion fires. The header path restarts as in IDLE; the open packet's carry is discarded.
- Reset (any time, including mid-packet): state=IDLE, out_tvalid=0, hdr_pend=0, carry_keep=0. Data regs are don't-care. In-flight packet is discarded.

Test Plan:
1. Header-only packet: in_tkeep=0x0000_0000_FFFF_FFFF, tlast=1, hvalid=1 -> one out beat: tkeep=0, tlast=1, hvalid=1, hdr=in_tdata[255:0].
2. Header + 16B payload, in_tkeep bits 0..47 set, tlast=1 -> one out beat: tkeep=0xFFFF, out_tdata[127:0]=in_tdata[383:256].
3. Two beats, beat1 full, beat2 in_tkeep=0xFFFF_FFFF, tlast -> one out beat: tkeep all-ones, tdata={beat2[255:0], beat1[511:256]}, tlast=1.
4. Two full beats, tlast on beat2 -> two out beats: full/tlast=0, then tkeep=0xFFFF_FFFF/tlast=1. in_tready=0 during the TAIL cycle.
5. Backpressure: out_tready=0 for 5 cycles mid-packet -> in_tready=0, out_* stable, byte stream matches reference model with no loss or duplication.
6. rst_n=0 for 1 cycle mid-packet (state BODY) -> out_tvalid=0 next cycle. The following fresh SOP packet is output correctly with hvalid=1.
